// File: rtl/datapath_pkg.sv
// Shared datapath constants and the MEM/WB control bundle.
package datapath_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [ADDR_W-1:0] HI_REG = ADDR_W'(15);

  // Control fields carried from MEM into WB.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              write_op2;
    logic              mem_to_reg;
    logic [ADDR_W-1:0] dest1;
    logic [ADDR_W-1:0] dest2;
  } wb_ctrl_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bus bundle of the write-back stage: MEM-stage inputs, MDU handshake and
// register-file write ports. slave = arbiter side, master = surrounding datapath.
interface writeback_arbiter_if;
  import datapath_pkg::*;

  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic              mem_reg_write;
  logic              mem_write_op2;
  logic              mem_mem_to_reg;
  logic [ADDR_W-1:0] mem_dest1;
  logic [ADDR_W-1:0] mem_dest2;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;
  logic [DATA_W-1:0] mem_op2_data;

  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_dest;
  logic [DATA_W-1:0] mdu_lo;
  logic [DATA_W-1:0] mdu_hi;

  logic              RegWrite;
  logic              WriteOP2;
  logic [ADDR_W-1:0] WriteReg1;
  logic [ADDR_W-1:0] WriteReg2;
  logic [DATA_W-1:0] WriteData1;
  logic [DATA_W-1:0] WriteData2;
  logic              stall_req;

  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_write_op2, mem_mem_to_reg,
    output mem_dest1, mem_dest2, mem_alu_result, mem_load_data, mem_op2_data,
    output mdu_valid, mdu_dest, mdu_lo, mdu_hi,
    input  mdu_ready, RegWrite, WriteOP2, WriteReg1, WriteReg2, WriteData1, WriteData2,
    input  stall_req
  );

  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_write_op2, mem_mem_to_reg,
    input  mem_dest1, mem_dest2, mem_alu_result, mem_load_data, mem_op2_data,
    input  mdu_valid, mdu_dest, mdu_lo, mdu_hi,
    output mdu_ready, RegWrite, WriteOP2, WriteReg1, WriteReg2, WriteData1, WriteData2,
    output stall_req
  );

endinterface

// File: rtl/mdu_hold_buffer.sv
// One-entry holding buffer for MDU results, with starvation counter that
// requests an upstream bubble once a full entry has waited too long.
module mdu_hold_buffer
  import datapath_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_dest,
  input  logic [DATA_W-1:0] mdu_lo,
  input  logic [DATA_W-1:0] mdu_hi,
  input  logic              drain,
  output logic              mdu_ready,
  output logic              buf_full,
  output logic [ADDR_W-1:0] buf_dest,
  output logic [DATA_W-1:0] buf_lo,
  output logic [DATA_W-1:0] buf_hi,
  output logic              stall_req
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept;

  // Handshake, entry replacement and starvation count.
  always_comb begin
    mdu_ready = !full_q | drain;
    accept    = mdu_valid & mdu_ready;
    full_d    = full_q;
    dest_d    = dest_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    if (accept) begin
      // Drain and load in the same cycle simply replaces the entry.
      full_d = 1'b1;
      dest_d = mdu_dest;
      lo_d   = mdu_lo;
      hi_d   = mdu_hi;
    end else if (drain) begin
      full_d = 1'b0;
    end
    if (!full_q || drain) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Buffer and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      dest_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      cnt_q  <= cnt_d;
    end
  end

  assign buf_full  = full_q;
  assign buf_dest  = dest_q;
  assign buf_lo    = lo_q;
  assign buf_hi    = hi_q;
  assign stall_req = full_q & (cnt_q == CntMax);

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back stage: MEM/WB register, result select, and arbitration of the
// register-file write ports between the pipeline and the MDU buffer.
module writeback_arbiter
  import datapath_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave bus
);

  wb_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] op2_q, op2_d;

  logic              wb_write;
  logic              drain;
  logic              buf_full;
  logic [ADDR_W-1:0] buf_dest;
  logic [DATA_W-1:0] buf_lo;
  logic [DATA_W-1:0] buf_hi;

  // Next WB register contents: a bubble on stall or flush.
  always_comb begin
    ctrl_d = '0;
    alu_d  = '0;
    load_d = '0;
    op2_d  = '0;
    if (!(bus.stall || bus.flush)) begin
      ctrl_d.valid      = bus.mem_valid;
      ctrl_d.reg_write  = bus.mem_reg_write;
      ctrl_d.write_op2  = bus.mem_write_op2;
      ctrl_d.mem_to_reg = bus.mem_mem_to_reg;
      ctrl_d.dest1      = bus.mem_dest1;
      ctrl_d.dest2      = bus.mem_dest2;
      alu_d             = bus.mem_alu_result;
      load_d            = bus.mem_load_data;
      op2_d             = bus.mem_op2_data;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      load_q <= '0;
      op2_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      load_q <= load_d;
      op2_q  <= op2_d;
    end
  end

  assign wb_write = ctrl_q.valid & ctrl_q.reg_write;
  // The buffer only gets the ports when the pipeline leaves them free.
  assign drain    = buf_full & !wb_write;

  mdu_hold_buffer #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .mdu_valid (bus.mdu_valid),
    .mdu_dest  (bus.mdu_dest),
    .mdu_lo    (bus.mdu_lo),
    .mdu_hi    (bus.mdu_hi),
    .drain     (drain),
    .mdu_ready (bus.mdu_ready),
    .buf_full  (buf_full),
    .buf_dest  (buf_dest),
    .buf_lo    (buf_lo),
    .buf_hi    (buf_hi),
    .stall_req (bus.stall_req)
  );

  // Write-port mux; driven only from registered state.
  always_comb begin
    bus.RegWrite   = 1'b0;
    bus.WriteOP2   = 1'b0;
    bus.WriteReg1  = '0;
    bus.WriteReg2  = '0;
    bus.WriteData1 = '0;
    bus.WriteData2 = '0;
    if (wb_write) begin
      bus.RegWrite   = 1'b1;
      bus.WriteOP2   = ctrl_q.write_op2;
      bus.WriteReg1  = ctrl_q.dest1;
      bus.WriteData1 = ctrl_q.mem_to_reg ? load_q : alu_q;
      bus.WriteReg2  = ctrl_q.dest2;
      bus.WriteData2 = op2_q;
    end else if (drain) begin
      bus.RegWrite   = 1'b1;
      bus.WriteOP2   = 1'b1;
      bus.WriteReg1  = buf_dest;
      bus.WriteData1 = buf_lo;
      bus.WriteReg2  = HI_REG;
      bus.WriteData2 = buf_hi;
    end
  end

endmodule
